// File: rtl/dsp_mac_sequencer_pkg.sv
// Shared types and OPMODE opcodes for the DSP48A1 MAC sequencer.
// A tag travels alongside each operand pair so OPMODE and capture line up with the slice pipeline.
package dsp_mac_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic vld;
        logic first;
        logic last;
    } tag_t;

    localparam logic [7:0] OPM_IDLE     = 8'h00;
    localparam logic [7:0] OPM_FIRST_Z0 = 8'h01;
    localparam logic [7:0] OPM_HOLD     = 8'h08;
    localparam logic [7:0] OPM_ACC      = 8'h09;
    localparam logic [7:0] OPM_FIRST_C  = 8'h0D;

    // Bubbles before the first tap clear P; bubbles after it hold P.
    function automatic logic [7:0] tag_opmode(input tag_t tag, input logic use_bias,
                                              input logic started);
        if (tag.first)
            return use_bias ? OPM_FIRST_C : OPM_FIRST_Z0;
        if (tag.vld)
            return OPM_ACC;
        if (started)
            return OPM_HOLD;
        return OPM_IDLE;
    endfunction

endpackage

// File: rtl/dsp_mac_sequencer_tag_pipe.sv
// Delay line for {vld,first,last} tags, with taps at the OPMODE stage and at the P capture stage.
// Stage k is valid k+1 cycles after the tag was issued, i.e. k cycles after its operands are driven.
module dsp_mac_sequencer_tag_pipe
    import dsp_mac_sequencer_pkg::*;
#(
    parameter int OPM_DLY = 1,
    parameter int CAP_DLY = 3
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_in,
    output tag_t opm_tag,
    output logic cap_last
);

    logic [CAP_DLY:0] last_sr;

    always_ff @(posedge clk) begin
        if (rst)
            last_sr <= '0;
        else
            last_sr <= {last_sr[CAP_DLY-1:0], tag_in.last};
    end

    assign cap_last = last_sr[CAP_DLY];

    generate
        if (OPM_DLY == 0) begin : g_opm_comb
            assign opm_tag = tag_in;
        end else begin : g_opm_reg
            tag_t [OPM_DLY-1:0] tags;

            always_ff @(posedge clk) begin
                if (rst) begin
                    tags <= '0;
                end else begin
                    tags[0] <= tag_in;
                    for (int k = 1; k < OPM_DLY; k++)
                        tags[k] <= tags[k-1];
                end
            end

            assign opm_tag = tags[OPM_DLY-1];
        end
    endgenerate

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Sequences one DSP48A1 slice through an N-tap unsigned dot product (optionally biased)
// and returns the 48-bit sum and final CARRYOUT over a valid/ready handshake.
//   state | meaning
//   IDLE  | waiting for a job command
//   RUN   | one tag per cycle: operands on handshake, bubble otherwise
//   DRAIN | all tags issued, waiting for the last tag to reach P
//   DONE  | result held until accepted
module dsp_mac_sequencer
    import dsp_mac_sequencer_pkg::*;
#(
    parameter int PIPE_AB    = 1,
    parameter int PIPE_M     = 1,
    parameter int PIPE_P     = 1,
    parameter int OPMODE_REG = 1,
    parameter int LEN_W      = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [47:0]      cmd_bias,
    input  logic             cmd_use_bias,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [17:0]      op_a,
    input  logic [17:0]      op_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [47:0]      res_data,
    output logic             res_carry,
    output logic [17:0]      DSP_A,
    output logic [17:0]      DSP_B,
    output logic [47:0]      DSP_C,
    output logic [17:0]      DSP_D,
    output logic [7:0]       DSP_OPMODE,
    output logic             DSP_CE,
    output logic             DSP_RST,
    input  logic [47:0]      DSP_P,
    input  logic             DSP_CARRYOUT
);

    localparam int OPM_DLY = PIPE_AB + PIPE_M - OPMODE_REG;
    localparam int CAP_DLY = PIPE_AB + PIPE_M + PIPE_P;

    state_t           state;
    logic [LEN_W-1:0] cnt;
    logic             first_pend;
    logic             use_bias;
    logic             started;
    logic             bias_sel;
    logic             cmd_hs;
    logic             op_hs;
    tag_t             tag_in;
    tag_t             opm_tag;
    logic             cap_last;

    assign cmd_hs   = cmd_valid & cmd_ready;
    assign op_hs    = op_valid & op_ready;
    assign bias_sel = (state == ST_IDLE) ? cmd_use_bias : use_bias;

    assign DSP_D   = '0;
    assign DSP_CE  = ~RST;
    assign DSP_RST = RST;

    // A zero-length job still sends one first/last tag so the bias (or zero) reaches P.
    always_comb begin
        tag_in = '0;
        if (cmd_hs && cmd_len == '0)
            tag_in = '{vld: 1'b0, first: 1'b1, last: 1'b1};
        else if (op_hs)
            tag_in = '{vld: 1'b1, first: first_pend, last: (cnt == LEN_W'(1))};
    end

    dsp_mac_sequencer_tag_pipe #(
        .OPM_DLY (OPM_DLY),
        .CAP_DLY (CAP_DLY)
    ) u_tag_pipe (
        .clk      (CLK),
        .rst      (RST),
        .tag_in   (tag_in),
        .opm_tag  (opm_tag),
        .cap_last (cap_last)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            cmd_ready  <= 1'b1;
            op_ready   <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_carry  <= 1'b0;
            cnt        <= '0;
            first_pend <= 1'b0;
            use_bias   <= 1'b0;
            started    <= 1'b0;
            DSP_A      <= '0;
            DSP_B      <= '0;
            DSP_C      <= '0;
            DSP_OPMODE <= OPM_IDLE;
        end else begin
            DSP_A      <= op_hs ? op_a : '0;
            DSP_B      <= op_hs ? op_b : '0;
            DSP_OPMODE <= tag_opmode(opm_tag, bias_sel, started);
            if (opm_tag.last)
                started <= 1'b0;
            else if (opm_tag.first)
                started <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (cmd_hs) begin
                        cnt        <= cmd_len;
                        first_pend <= 1'b1;
                        use_bias   <= cmd_use_bias;
                        DSP_C      <= cmd_bias;
                        cmd_ready  <= 1'b0;
                        if (cmd_len == '0) begin
                            state <= ST_DRAIN;
                        end else begin
                            state    <= ST_RUN;
                            op_ready <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (op_hs) begin
                        cnt        <= cnt - LEN_W'(1);
                        first_pend <= 1'b0;
                        if (cnt == LEN_W'(1)) begin
                            state    <= ST_DRAIN;
                            op_ready <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (cap_last) begin
                        res_data  <= DSP_P;
                        res_carry <= DSP_CARRYOUT;
                        res_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: behavioural DSP48A1 slice, plain-arithmetic dot-product model,
// directed cases with literal results, then randomized jobs.
module tb_dsp_mac_sequencer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_len = '0;
    logic [47:0] cmd_bias = '0;
    logic        cmd_use_bias = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [17:0] op_a = '0;
    logic [17:0] op_b = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [47:0] res_data;
    logic        res_carry;
    logic [17:0] DSP_A, DSP_B, DSP_D;
    logic [47:0] DSP_C;
    logic [7:0]  DSP_OPMODE;
    logic        DSP_CE, DSP_RST;

    always #5 CLK = ~CLK;

    // Slice model: A1/B1 -> M -> P, OPMODE and C registered once, CARRYOUT with P.
    logic [17:0] s_a1 = '0, s_b1 = '0;
    logic [35:0] s_m = '0;
    logic [7:0]  s_opm = '0;
    logic [47:0] s_c = '0, s_p = '0;
    logic        s_co = 1'b0;
    logic [47:0] s_x, s_z;
    logic [48:0] s_sum;

    always_comb begin
        s_x = '0;
        s_z = '0;
        case (s_opm[1:0])
            2'd1: s_x = {12'd0, s_m};
            2'd2: s_x = s_p;
            2'd3: s_x = {DSP_D[11:0], s_a1, s_b1};
            default: s_x = '0;
        endcase
        case (s_opm[3:2])
            2'd2: s_z = s_p;
            2'd3: s_z = s_c;
            default: s_z = '0;
        endcase
        s_sum = {1'b0, s_x} + {1'b0, s_z};
    end

    always @(posedge CLK) begin
        if (DSP_RST) begin
            s_a1 <= '0; s_b1 <= '0; s_m <= '0; s_opm <= '0;
            s_c <= '0; s_p <= '0; s_co <= 1'b0;
        end else if (DSP_CE) begin
            s_a1  <= DSP_A;
            s_b1  <= DSP_B;
            s_m   <= 36'(s_a1) * 36'(s_b1);
            s_opm <= DSP_OPMODE;
            s_c   <= DSP_C;
            s_p   <= s_sum[47:0];
            s_co  <= s_sum[48];
        end
    end

    dsp_mac_sequencer dut (
        .CLK          (CLK),
        .RST          (RST),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_len      (cmd_len),
        .cmd_bias     (cmd_bias),
        .cmd_use_bias (cmd_use_bias),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .op_a         (op_a),
        .op_b         (op_b),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_carry    (res_carry),
        .DSP_A        (DSP_A),
        .DSP_B        (DSP_B),
        .DSP_C        (DSP_C),
        .DSP_D        (DSP_D),
        .DSP_OPMODE   (DSP_OPMODE),
        .DSP_CE       (DSP_CE),
        .DSP_RST      (DSP_RST),
        .DSP_P        (s_p),
        .DSP_CARRYOUT (s_co)
    );

    int          vectors = 0;
    int          miscompares = 0;
    int          busy = 0;
    int          ops_left = 0;
    logic [48:0] exp_q[$];
    logic [17:0] ja[256];
    logic [17:0] jb[256];
    int          gaps[256];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the job-level model.
    always @(negedge CLK) begin
        if (!RST) begin
            chk("cmd_ready", 64'(cmd_ready), 64'(busy == 0));
            chk("op_ready", 64'(op_ready), 64'(ops_left > 0));
            chk("dsp_ce", 64'(DSP_CE), 64'd1);
            chk("dsp_d", 64'(DSP_D), 64'd0);
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    chk("res_valid_spurious", 64'(res_valid), 64'd0);
                end else begin
                    chk("res_data", 64'(res_data), 64'(exp_q[0][47:0]));
                    chk("res_carry", 64'(res_carry), 64'(exp_q[0][48]));
                    if (res_ready)
                        void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic issue_cmd(input int len, input logic [47:0] bias, input logic ub);
        int n;
        cmd_valid = 1'b1;
        cmd_len = 8'(len);
        cmd_bias = bias;
        cmd_use_bias = ub;
        n = 0;
        @(negedge CLK);
        while (!cmd_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("cmd_hs_timeout", 64'(n < 50), 64'd1);
        @(posedge CLK);
        #1;
        cmd_valid = 1'b0;
        busy = 1;
        ops_left = len;
    endtask

    task automatic send_op(input logic [17:0] a, input logic [17:0] b, input int gap);
        int n;
        op_a = 18'($urandom);
        op_b = 18'($urandom);
        if (gap > 0) begin
            repeat (gap) @(posedge CLK);
            #1;
        end
        op_valid = 1'b1;
        op_a = a;
        op_b = b;
        n = 0;
        @(negedge CLK);
        while (!op_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("op_hs_timeout", 64'(n < 50), 64'd1);
        @(posedge CLK);
        #1;
        op_valid = 1'b0;
        op_a = 18'($urandom);
        op_b = 18'($urandom);
        ops_left--;
    endtask

    task automatic finish_job(input int hold, input bit lit, input logic [47:0] lit_d,
                              input logic lit_c);
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!res_valid && n < 20);
        chk("res_latency", 64'(n), 64'd5);
        if (lit) begin
            chk("lit_res_data", 64'(res_data), 64'(lit_d));
            chk("lit_res_carry", 64'(res_carry), 64'(lit_c));
        end
        @(posedge CLK);
        repeat (hold) @(posedge CLK);
        #1;
        res_ready = 1'b1;
        @(negedge CLK);
        chk("res_valid_held", 64'(res_valid), 64'd1);
        @(posedge CLK);
        #1;
        res_ready = 1'b0;
        busy = 0;
    endtask

    task automatic run_job(input int len, input logic [47:0] bias, input logic ub, input int hold,
                           input bit lit, input logic [47:0] lit_d, input logic lit_c);
        logic [48:0] s;
        logic [47:0] acc;
        logic        cy;
        acc = ub ? bias : 48'd0;
        cy = 1'b0;
        for (int i = 0; i < len; i++) begin
            s = {1'b0, acc} + {13'd0, 36'(ja[i]) * 36'(jb[i])};
            acc = s[47:0];
            cy = s[48];
        end
        exp_q.push_back({cy, acc});
        issue_cmd(len, bias, ub);
        for (int i = 0; i < len; i++)
            send_op(ja[i], jb[i], gaps[i]);
        finish_job(hold, lit, lit_d, lit_c);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        cmd_valid = 1'b0;
        op_valid = 1'b0;
        res_ready = 1'b0;
        exp_q.delete();
        busy = 0;
        ops_left = 0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    task automatic load_t1(input int g0, input int g);
        ja[0] = 18'd2; ja[1] = 18'd3; ja[2] = 18'd4;
        jb[0] = 18'd5; jb[1] = 18'd6; jb[2] = 18'd7;
        gaps[0] = g0; gaps[1] = g; gaps[2] = g;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          len;
        logic [47:0] bias;
        bit          big;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_op_ready", 64'(op_ready), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_res_data", 64'(res_data), 64'd0);
        chk("rst_res_carry", 64'(res_carry), 64'd0);
        chk("rst_dsp_a", 64'(DSP_A), 64'd0);
        chk("rst_dsp_b", 64'(DSP_B), 64'd0);
        chk("rst_dsp_c", 64'(DSP_C), 64'd0);
        chk("rst_dsp_d", 64'(DSP_D), 64'd0);
        chk("rst_dsp_opmode", 64'(DSP_OPMODE), 64'd0);
        chk("rst_dsp_ce", 64'(DSP_CE), 64'd0);
        chk("rst_dsp_rst", 64'(DSP_RST), 64'd1);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        load_t1(0, 0);
        run_job(3, 48'd0, 1'b0, 0, 1'b1, 48'd56, 1'b0);

        ja[0] = 18'd1; ja[1] = 18'd1; jb[0] = 18'd1; jb[1] = 18'd2;
        gaps[0] = 0; gaps[1] = 0;
        run_job(2, 48'd100, 1'b1, 0, 1'b1, 48'd103, 1'b0);

        load_t1(3, 2);
        run_job(3, 48'd0, 1'b0, 0, 1'b1, 48'd56, 1'b0);

        ja[0] = 18'd1; jb[0] = 18'd1; gaps[0] = 0;
        run_job(1, 48'hFFFF_FFFF_FFFF, 1'b1, 0, 1'b1, 48'd0, 1'b1);

        run_job(0, 48'd5, 1'b1, 0, 1'b1, 48'd5, 1'b0);
        run_job(0, 48'd5, 1'b0, 0, 1'b1, 48'd0, 1'b0);

        ja[0] = 18'd1; ja[1] = 18'd1; jb[0] = 18'd1; jb[1] = 18'd2;
        gaps[0] = 0; gaps[1] = 0;
        run_job(2, 48'd100, 1'b1, 10, 1'b1, 48'd103, 1'b0);

        load_t1(0, 0);
        issue_cmd(3, 48'd0, 1'b0);
        send_op(ja[0], jb[0], 0);
        do_reset();
        @(negedge CLK);
        chk("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("midrst_res_valid", 64'(res_valid), 64'd0);
        chk("midrst_op_ready", 64'(op_ready), 64'd0);
        repeat (8) @(posedge CLK);
        #1;
        run_job(3, 48'd0, 1'b0, 0, 1'b1, 48'd56, 1'b0);

        for (int j = 0; j < 25; j++) begin
            len = $urandom_range(0, 12);
            big = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < len; i++) begin
                ja[i] = big ? 18'h3FFFF : 18'($urandom);
                jb[i] = big ? 18'h3FFFF : 18'($urandom);
                gaps[i] = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
            end
            bias = {16'($urandom), 32'($urandom)};
            run_job(len, bias, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                    1'b0, 48'd0, 1'b0);
        end

        for (int i = 0; i < 255; i++) begin
            ja[i] = 18'($urandom);
            jb[i] = 18'($urandom);
            gaps[i] = 0;
        end
        bias = {16'($urandom), 32'($urandom)};
        run_job(255, bias, 1'b1, 1, 1'b0, 48'd0, 1'b0);

        repeat (4) @(posedge CLK);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
